// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the button event controller.
//   - btn_state_e : 3-bit debounce FSM encoding (ZERO=000 .. ONE3=111)
//   - *_DEF       : default values for NUM_BTN, CNT_MAX and CNT_W
//   - is_one_side : true for the four states that report a pressed level
package btn_pkg;

    localparam int NUM_BTN_DEF = 4;
    localparam int CNT_MAX_DEF = 1_000_000;  // 10 ms at 100 MHz
    localparam int CNT_W_DEF   = 20;

    typedef enum logic [2:0] {
        ZERO  = 3'b000,
        ZERO1 = 3'b001,
        ZERO2 = 3'b010,
        ZERO3 = 3'b011,
        ONE   = 3'b100,
        ONE1  = 3'b101,
        ONE2  = 3'b110,
        ONE3  = 3'b111
    } btn_state_e;

    function automatic logic is_one_side(btn_state_e s);
        return (s inside {ONE, ONE1, ONE2, ONE3});
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one debounce channel.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   tick         : shared debounce tick (one cycle per tick period)
//   btn          : raw button level, already synchronised to clk
//   state        : current FSM state (observable for checkers and level decode)
//   press_pulse  : high in the cycle whose edge performs ZERO3 -> ONE
//   rel_pulse    : high in the cycle whose edge performs ONE3 -> ZERO
module btn_debounce_ch
    import btn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn,
    output btn_state_e state,
    output logic       press_pulse,
    output logic       rel_pulse
);

    btn_state_e state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ZERO;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving a stable state needs only the opposite level; each further
    // step needs a tick with that level still present, so a level must
    // survive three tick boundaries before the change is accepted.
    always_comb begin
        state_nxt   = state;
        press_pulse = 1'b0;
        rel_pulse   = 1'b0;
        unique case (state)
            ZERO:  if (btn) state_nxt = ZERO1;
            ZERO1: if (!btn) state_nxt = ZERO; else if (tick) state_nxt = ZERO2;
            ZERO2: if (!btn) state_nxt = ZERO; else if (tick) state_nxt = ZERO3;
            ZERO3: begin
                if (!btn) begin
                    state_nxt = ZERO;
                end else if (tick) begin
                    state_nxt   = ONE;
                    press_pulse = 1'b1;
                end
            end
            ONE:   if (!btn) state_nxt = ONE1;
            ONE1:  if (btn) state_nxt = ONE; else if (tick) state_nxt = ONE2;
            ONE2:  if (btn) state_nxt = ONE; else if (tick) state_nxt = ONE3;
            ONE3: begin
                if (btn) begin
                    state_nxt = ONE;
                end else if (tick) begin
                    state_nxt = ZERO;
                    rel_pulse = 1'b1;
                end
            end
            default: state_nxt = ZERO;
        endcase
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: debounces NUM_BTN buttons and queues press/release events.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   btn_in       : raw synchronised button levels
//   btn_level    : debounced level per channel
//   evt_valid    : event presented on evt_id / evt_press
//   evt_ready    : consumer accepts the presented event
//   evt_id       : channel of the presented event
//   evt_press    : 1 = press, 0 = release
//   evt_overrun  : one-cycle pulse when a pending event is overwritten
//
// Handshake: an event transfers on a rising edge where evt_valid and
// evt_ready are both high. Once evt_valid is high, evt_id and evt_press hold
// until that transfer; evt_valid never drops without a transfer (except reset).
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEF,
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int ID_W   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic               evt_press,
    output logic               evt_overrun
);

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    btn_state_e         ch_state [NUM_BTN];
    logic [NUM_BTN-1:0] press_ev;
    logic [NUM_BTN-1:0] rel_ev;
    logic [NUM_BTN-1:0] pend, pend_nxt;
    logic [NUM_BTN-1:0] ptype, ptype_nxt;  // 1 = press
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_idx;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_vld;
    logic               load;
    logic               over;

    // Shared tick counter: tick is high for the whole cycle in which cnt == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(CNT_MAX - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == '0);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .btn         (btn_in[g]),
            .state       (ch_state[g]),
            .press_pulse (press_ev[g]),
            .rel_pulse   (rel_ev[g])
        );
        assign btn_level[g] = is_one_side(ch_state[g]);
    end

    // The output register is free when empty or when its event transfers now.
    assign load = !evt_valid || evt_ready;

    // Round-robin pick: scan offsets high to low so the lowest offset from
    // rr_ptr that has a pending event wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        rr_idx  = '0;
        for (int off = NUM_BTN - 1; off >= 0; off--) begin
            rr_idx = ID_W'((int'(rr_ptr) + off) % NUM_BTN);
            if (pend[rr_idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = rr_idx;
            end
        end
    end

    // Slot update. A new event in the slot being granted this edge simply
    // refills it: the old event leaves through the output register, so
    // nothing is lost and no overrun is reported.
    always_comb begin
        pend_nxt  = pend;
        ptype_nxt = ptype;
        over      = 1'b0;
        if (load && gnt_vld) begin
            pend_nxt[gnt_id] = 1'b0;
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            if (press_ev[i] || rel_ev[i]) begin
                if (pend[i] && !(load && gnt_vld && gnt_id == ID_W'(i))) begin
                    over = 1'b1;
                end
                pend_nxt[i]  = 1'b1;
                ptype_nxt[i] = press_ev[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            ptype       <= '0;
            rr_ptr      <= '0;
            evt_valid   <= 1'b0;
            evt_id      <= '0;
            evt_press   <= 1'b0;
            evt_overrun <= 1'b0;
        end else begin
            pend        <= pend_nxt;
            ptype       <= ptype_nxt;
            evt_overrun <= over;
            if (load) begin
                if (gnt_vld) begin
                    evt_valid <= 1'b1;
                    evt_id    <= gnt_id;
                    evt_press <= ptype[gnt_id];
                    rr_ptr    <= (gnt_id == ID_W'(NUM_BTN - 1)) ? '0 : gnt_id + ID_W'(1);
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl with a short tick period (CNT_MAX = 8).
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_in = '0;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_id;
    logic       evt_press;
    logic       evt_overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    int valid_cyc = 0;
    int hs_cyc[$];
    logic [2:0] exp_q[$];  // {id, press}
    logic       stall_prev = 1'b0;
    logic [2:0] held = '0;

    btn_event_ctrl #(.NUM_BTN(4), .CNT_MAX(8), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .evt_press   (evt_press),
        .evt_overrun (evt_overrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_state);
        rst_n = 1'b0;
        #1;
        if (check_state) begin
            chk("rst_level", 32'(btn_level), 32'h0);
            chk("rst_valid", 32'(evt_valid), 32'h0);
            chk("rst_id", 32'(evt_id), 32'h0);
            chk("rst_press", 32'(evt_press), 32'h0);
            chk("rst_overrun", 32'(evt_overrun), 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- driver helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input logic [1:0] id, input logic press);
        exp_q.push_back({id, press});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (evt_overrun) ovr_cnt++;
            if (evt_valid) valid_cyc++;
            if (stall_prev) begin
                checks++;
                if ({evt_valid, evt_id, evt_press} !== {1'b1, held}) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b id=%0d p=%0b expected v=1 id=%0d p=%0b",
                             evt_valid, evt_id, evt_press, held[2:1], held[0]);
                end
            end
            if (evt_valid && evt_ready) begin
                checks++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_evt: got id=%0d p=%0b expected no event (cycle %0d)",
                             evt_id, evt_press, cyc);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    if ({evt_id, evt_press} !== e) begin
                        failures++;
                        $display("FAIL evt: got id=%0d p=%0b expected id=%0d p=%0b (cycle %0d)",
                                 evt_id, evt_press, e[2:1], e[0], cyc);
                    end
                end
            end
            stall_prev = evt_valid && !evt_ready;
            held       = {evt_id, evt_press};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int v0;

        // Press then release on ch0, exact debounce timing.
        do_reset(1'b1);
        evt_ready = 1'b1;
        btn_in    = 4'b0001;
        expect_evt(2'd0, 1'b1);
        wait_cyc(24);
        chk("s1_level_before", 32'(btn_level), 32'h0);
        step();
        chk("s1_level_rise", 32'(btn_level), 32'h1);
        chk("s1_valid_lat0", 32'(evt_valid), 32'h0);
        step();
        chk("s1_valid_lat1", 32'(evt_valid), 32'h1);
        step();
        chk("s1_valid_drop", 32'(evt_valid), 32'h0);
        btn_in = 4'b0000;
        expect_evt(2'd0, 1'b0);
        wait_cyc(40);
        chk("s1_level_fall", 32'(btn_level), 32'h0);
        chk("s1_drained", 32'(exp_q.size()), 32'h0);

        // Short glitch on ch2 must be ignored.
        v0 = valid_cyc;
        btn_in = 4'b0100;
        wait_cyc(5);
        btn_in = 4'b0000;
        wait_cyc(40);
        chk("s2_level", 32'(btn_level), 32'h0);
        chk("s2_no_valid", 32'(valid_cyc - v0), 32'h0);

        // All four rise together: ids 0..3 on consecutive cycles.
        do_reset(1'b0);
        evt_ready = 1'b1;
        hs_cyc.delete();
        btn_in = 4'b1111;
        for (int i = 0; i < 4; i++) expect_evt(2'(i), 1'b1);
        wait_cyc(40);
        chk("s3_level", 32'(btn_level), 32'hF);
        chk("s3_count", 32'(hs_cyc.size()), 32'd4);
        if (hs_cyc.size() == 4) chk("s3_consec", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);
        btn_in = 4'b0000;
        for (int i = 0; i < 4; i++) expect_evt(2'(i), 1'b0);
        wait_cyc(40);
        chk("s3_drained", 32'(exp_q.size()), 32'h0);

        // Overrun on ch1 while the consumer stalls.
        v0 = ovr_cnt;
        evt_ready = 1'b0;
        btn_in = 4'b0010;
        expect_evt(2'd1, 1'b1);
        wait_cyc(40);
        btn_in = 4'b0000;
        wait_cyc(40);
        btn_in = 4'b0010;
        expect_evt(2'd1, 1'b1);
        wait_cyc(40);
        chk("s4_overrun", 32'(ovr_cnt - v0), 32'd1);
        chk("s4_stalled", 32'(exp_q.size()), 32'd2);
        evt_ready = 1'b1;
        wait_cyc(10);
        chk("s4_drained", 32'(exp_q.size()), 32'h0);
        btn_in = 4'b0000;
        expect_evt(2'd1, 1'b0);
        wait_cyc(40);
        chk("s4_rel_drained", 32'(exp_q.size()), 32'h0);

        // Round-robin resumes after the last grant (2): 3 before 0.
        do_reset(1'b0);
        evt_ready = 1'b1;
        btn_in = 4'b0100;
        expect_evt(2'd2, 1'b1);
        wait_cyc(40);
        btn_in = 4'b1101;
        expect_evt(2'd3, 1'b1);
        expect_evt(2'd0, 1'b1);
        wait_cyc(40);
        btn_in = 4'b0000;
        expect_evt(2'd2, 1'b0);
        expect_evt(2'd3, 1'b0);
        expect_evt(2'd0, 1'b0);
        wait_cyc(40);
        chk("s5_drained", 32'(exp_q.size()), 32'h0);
        chk("s5_overrun_total", 32'(ovr_cnt - v0), 32'd1);

        // Reset while an event is presented discards everything.
        evt_ready = 1'b0;
        btn_in = 4'b0010;
        wait_cyc(40);
        chk("s6_valid_before", 32'(evt_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("s6_valid_async", 32'(evt_valid), 32'h0);
        chk("s6_level_async", 32'(btn_level), 32'h0);
        btn_in = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        evt_ready = 1'b1;
        v0 = valid_cyc;
        wait_cyc(60);
        chk("s6_no_replay", 32'(valid_cyc - v0), 32'h0);
        chk("s6_level", 32'(btn_level), 32'h0);
        chk("final_queue", 32'(exp_q.size()), 32'h0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
